// File: rtl/lane_pkg.sv
// lane_pkg: lane state encodings and width helpers shared by the occupancy counter.
package lane_pkg;

    typedef logic [2:0] lane_state_t;

    localparam lane_state_t IDLE   = 3'd0;
    localparam lane_state_t EN_A   = 3'd1;
    localparam lane_state_t EN_AB  = 3'd2;
    localparam lane_state_t EN_B   = 3'd3;
    localparam lane_state_t EX_B   = 3'd4;
    localparam lane_state_t EX_AB  = 3'd5;
    localparam lane_state_t EX_A   = 3'd6;
    localparam lane_state_t RESYNC = 3'd7;

    // Signed width holding occupancy plus or minus one pulse per lane.
    function automatic int net_width(input int cnt_w, input int n_lanes);
        return cnt_w + $clog2(n_lanes + 1) + 2;
    endfunction

    // Filtered {A,B} pair that a state implies was last seen.
    function automatic logic [1:0] phase_ab(input lane_state_t s);
        return (s == EN_A || s == EX_A) ? 2'b10 :
               (s == EN_AB || s == EX_AB) ? 2'b11 :
               (s == EN_B || s == EX_B) ? 2'b01 : 2'b00;
    endfunction

endpackage

// File: rtl/lane_fsm.sv
// lane_fsm: per-lane sensor synchroniser, debounce filters and passage FSM
// with registered entry/exit/error pulses.
module lane_fsm
    import lane_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a_i,
    input  logic b_i,
    output logic entry_o,
    output logic exit_o,
    output logic err_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [1:0] s1_q, s2_q, ab_q, ab_d;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    lane_state_t state_q, state_d;
    logic entry_q, entry_d, exit_q, exit_d, err_q, err_d;

    // Bit 1 is A, bit 0 is B; a bit flips once it has disagreed DEB_CYCLES edges in a row.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = (s2_q[i] != ab_q[i] && cnt_q[i] != LAST) ? cnt_q[i] + 1'b1 : '0;
            ab_d[i]  = (s2_q[i] != ab_q[i] && cnt_q[i] == LAST) ? s2_q[i] : ab_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        entry_d = 1'b0;
        exit_d  = 1'b0;
        err_d   = 1'b0;
        if (state_q == RESYNC) begin
            state_d = (ab_q == 2'b00) ? IDLE : RESYNC;
        end else if ((ab_q ^ phase_ab(state_q)) == 2'b11) begin
            state_d = RESYNC;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE:  state_d = (ab_q == 2'b10) ? EN_A : (ab_q == 2'b01) ? EX_B : IDLE;
                EN_A:  state_d = (ab_q == 2'b11) ? EN_AB : (ab_q == 2'b00) ? IDLE : EN_A;
                EN_AB: state_d = (ab_q == 2'b01) ? EN_B : (ab_q == 2'b10) ? EN_A : EN_AB;
                EN_B: begin
                    state_d = (ab_q == 2'b00) ? IDLE : (ab_q == 2'b11) ? EN_AB : EN_B;
                    entry_d = (ab_q == 2'b00);
                end
                EX_B:  state_d = (ab_q == 2'b11) ? EX_AB : (ab_q == 2'b00) ? IDLE : EX_B;
                EX_AB: state_d = (ab_q == 2'b10) ? EX_A : (ab_q == 2'b01) ? EX_B : EX_AB;
                EX_A: begin
                    state_d = (ab_q == 2'b00) ? IDLE : (ab_q == 2'b11) ? EX_AB : EX_A;
                    exit_d  = (ab_q == 2'b00);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            ab_q    <= '0;
            cnt_q   <= '{default: '0};
            state_q <= IDLE;
            entry_q <= 1'b0;
            exit_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s1_q    <= {a_i, b_i};
            s2_q    <= s1_q;
            ab_q    <= ab_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            entry_q <= entry_d;
            exit_q  <= exit_d;
            err_q   <= err_d;
        end
    end

    assign entry_o = entry_q;
    assign exit_o  = exit_q;
    assign err_o   = err_q;

endmodule

// File: rtl/lane_occupancy_counter.sv
// lane_occupancy_counter: N-lane car passage detection feeding a saturating
// lot occupancy counter with full/empty and sticky clip flags.
module lane_occupancy_counter
    import lane_pkg::*;
#(
    parameter int N_LANES    = 2,
    parameter int CNT_W      = 8,
    parameter int CAPACITY   = 50,
    parameter int DEB_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LANES-1:0] a,
    input  logic [N_LANES-1:0] b,
    input  logic               clr_count,
    output logic [N_LANES-1:0] entry_pulse,
    output logic [N_LANES-1:0] exit_pulse,
    output logic [N_LANES-1:0] seq_error,
    output logic [CNT_W-1:0]   occupancy,
    output logic               full,
    output logic               empty,
    output logic               overflow,
    output logic               underflow
);

    localparam int NW = net_width(CNT_W, N_LANES);
    localparam logic signed [NW-1:0] CAP_S = NW'(CAPACITY);
    localparam logic [CNT_W-1:0] CAP_U = CNT_W'(CAPACITY);

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        lane_fsm #(.DEB_CYCLES(DEB_CYCLES)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .a_i     (a[l]),
            .b_i     (b[l]),
            .entry_o (entry_pulse[l]),
            .exit_o  (exit_pulse[l]),
            .err_o   (seq_error[l])
        );
    end

    logic signed [NW-1:0] sum;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic ovf_q, ovf_d, unf_q, unf_d;

    // All lanes' pulses fold into one signed update before clipping.
    always_comb begin
        sum = NW'(occ_q);
        for (int i = 0; i < N_LANES; i++) begin
            sum = sum + NW'(entry_pulse[i]) - NW'(exit_pulse[i]);
        end
        occ_d = clr_count ? '0 : sum[NW-1] ? '0 : (sum > CAP_S) ? CAP_U : sum[CNT_W-1:0];
        ovf_d = ~clr_count & (ovf_q | (sum > CAP_S));
        unf_d = ~clr_count & (unf_q | sum[NW-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign occupancy = occ_q;
    assign full      = (occ_q == CAP_U);
    assign empty     = (occ_q == '0);
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_lane_occupancy_counter.sv
// tb_lane_occupancy_counter: directed table, hand sequences and randomized
// sensor activity checked against a passage-level reference model.
module tb_lane_occupancy_counter;

    localparam int N = 2, DEB = 4, CAP = 3, CW = 8;

    logic clk = 1'b0, rst = 1'b1, clr_count = 1'b0;
    logic [N-1:0] a = '0, b = '0;
    logic [N-1:0] entry_pulse, exit_pulse, seq_error;
    logic [CW-1:0] occupancy;
    logic full, empty, overflow, underflow;

    int checks = 0, failures = 0;
    int cnt_en = 0, cnt_ex = 0, cnt_err = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    lane_occupancy_counter #(
        .N_LANES(N), .CNT_W(CW), .CAPACITY(CAP), .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .clr_count(clr_count),
        .entry_pulse(entry_pulse), .exit_pulse(exit_pulse), .seq_error(seq_error),
        .occupancy(occupancy), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    // Reference model: sensor history window, gray-cycle phase walk, clipped sum.
    logic [3:0] hq[$];
    logic [3:0] mf;
    int mdir[N], mp[N];
    bit mres[N];
    logic [1:0] mlast[N];
    logic [N-1:0] xen = '0, xex = '0, xerr = '0;
    int xocc = 0, ms;
    bit xovf = 0, xunf = 0, mall;
    logic [1:0] mcur;

    function automatic logic [1:0] pat(input int dir, input int i);
        logic [1:0] p;
        case (i & 3)
            0: p = 2'b00;
            1: p = 2'b10;
            2: p = 2'b11;
            default: p = 2'b01;
        endcase
        return dir == 1 ? p : {p[0], p[1]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            hq = {};
            for (int k = 0; k < 8; k++) hq.push_back(4'b0);
            mf = '0;
            for (int l = 0; l < N; l++) begin
                mdir[l] = 0; mp[l] = 0; mres[l] = 0; mlast[l] = 2'b00;
            end
            xen = '0; xex = '0; xerr = '0; xocc = 0; xovf = 0; xunf = 0;
        end else begin
            ms = xocc + $countones(xen) - $countones(xex);
            if (clr_count) begin xocc = 0; xovf = 0; xunf = 0; end
            else if (ms > CAP) begin xocc = CAP; xovf = 1; end
            else if (ms < 0) begin xocc = 0; xunf = 1; end
            else xocc = ms;
            for (int l = 0; l < N; l++) begin
                xen[l] = 0; xex[l] = 0; xerr[l] = 0;
                mcur = {mf[l], mf[N+l]};
                if (mres[l]) begin
                    if (mcur == 2'b00) mres[l] = 0;
                end else if ((mcur ^ mlast[l]) == 2'b11) begin
                    xerr[l] = 1; mres[l] = 1; mdir[l] = 0;
                end else if (mcur != mlast[l]) begin
                    if (mdir[l] == 0) begin
                        mdir[l] = (mcur == 2'b10) ? 1 : 2; mp[l] = 1;
                    end else if (mcur == pat(mdir[l], mp[l] + 1)) begin
                        mp[l]++;
                        if (mp[l] == 4) begin
                            if (mdir[l] == 1) xen[l] = 1; else xex[l] = 1;
                            mdir[l] = 0;
                        end
                    end else if (mcur == pat(mdir[l], mp[l] - 1)) begin
                        mp[l]--;
                        if (mp[l] == 0) mdir[l] = 0;
                    end
                end
                mlast[l] = mcur;
            end
            for (int j = 0; j < 4; j++) begin
                mall = 1;
                for (int k = 1; k <= DEB; k++) if (hq[k][j] == mf[j]) mall = 0;
                if (mall) mf[j] = ~mf[j];
            end
            hq.push_front({b, a});
            void'(hq.pop_back());
        end
    end

    always @(negedge clk) begin
        cnt_en  += $countones(entry_pulse);
        cnt_ex  += $countones(exit_pulse);
        cnt_err += $countones(seq_error);
        if (mon_en) begin
            chk("m_entry", entry_pulse, xen);
            chk("m_exit", exit_pulse, xex);
            chk("m_err", seq_error, xerr);
            chk("m_occ", occupancy, xocc);
            chk("m_full", full, xocc == CAP);
            chk("m_empty", empty, xocc == 0);
            chk("m_ovf", overflow, xovf);
            chk("m_unf", underflow, xunf);
        end
    end

    typedef struct {
        logic [1:0] a, b;
        logic clr;
        int hold, en, ex, err, occ;
        logic full, ovf, unf;
    } step_t;
    step_t tbl[$];

    function automatic void add(logic [1:0] ra, rb, logic rc, int h, int e, x, r, o,
                                logic f, v, u);
        step_t s;
        s.a = ra; s.b = rb; s.clr = rc; s.hold = h; s.en = e; s.ex = x; s.err = r;
        s.occ = o; s.full = f; s.ovf = v; s.unf = u;
        tbl.push_back(s);
    endfunction

    task automatic drive(input logic [1:0] ra, rb, input int h);
        a = ra; b = rb;
        repeat (h) @(posedge clk);
        #1;
    endtask

    initial begin
        int e0, r0, x0, r, h;
        logic [1:0] cur[N];
        add(2'b01, 2'b00, 0, 10, 0, 0, 0, 0, 0, 0, 0);
        add(2'b01, 2'b01, 0, 10, 0, 0, 0, 0, 0, 0, 0);
        add(2'b00, 2'b01, 0, 10, 0, 0, 0, 0, 0, 0, 0);
        add(2'b00, 2'b00, 0, 10, 1, 0, 0, 1, 0, 0, 0);
        add(2'b01, 2'b00, 0, 10, 1, 0, 0, 1, 0, 0, 0);
        add(2'b00, 2'b00, 0, 10, 1, 0, 0, 1, 0, 0, 0);
        add(2'b01, 2'b00, 0, 10, 1, 0, 0, 1, 0, 0, 0);
        add(2'b01, 2'b01, 0, 10, 1, 0, 0, 1, 0, 0, 0);
        add(2'b01, 2'b00, 0, 10, 1, 0, 0, 1, 0, 0, 0);
        add(2'b00, 2'b00, 0, 10, 1, 0, 0, 1, 0, 0, 0);
        add(2'b00, 2'b01, 0, 10, 1, 0, 0, 1, 0, 0, 0);
        add(2'b01, 2'b01, 0, 10, 1, 0, 0, 1, 0, 0, 0);
        add(2'b01, 2'b00, 0, 10, 1, 0, 0, 1, 0, 0, 0);
        add(2'b00, 2'b00, 0, 10, 1, 1, 0, 0, 0, 0, 0);
        add(2'b10, 2'b00, 0, 3,  1, 1, 0, 0, 0, 0, 0);
        add(2'b00, 2'b00, 0, 10, 1, 1, 0, 0, 0, 0, 0);
        add(2'b10, 2'b10, 0, 10, 1, 1, 1, 0, 0, 0, 0);
        add(2'b00, 2'b10, 0, 10, 1, 1, 1, 0, 0, 0, 0);
        add(2'b00, 2'b00, 0, 10, 1, 1, 1, 0, 0, 0, 0);
        add(2'b10, 2'b00, 0, 10, 1, 1, 1, 0, 0, 0, 0);
        add(2'b10, 2'b10, 0, 10, 1, 1, 1, 0, 0, 0, 0);
        add(2'b00, 2'b10, 0, 10, 1, 1, 1, 0, 0, 0, 0);
        add(2'b00, 2'b00, 0, 10, 2, 1, 1, 1, 0, 0, 0);
        add(2'b01, 2'b00, 0, 10, 2, 1, 1, 1, 0, 0, 0);
        add(2'b01, 2'b01, 0, 10, 2, 1, 1, 1, 0, 0, 0);
        add(2'b00, 2'b01, 0, 10, 2, 1, 1, 1, 0, 0, 0);
        add(2'b00, 2'b00, 0, 10, 3, 1, 1, 2, 0, 0, 0);
        add(2'b01, 2'b10, 0, 10, 3, 1, 1, 2, 0, 0, 0);
        add(2'b11, 2'b11, 0, 10, 3, 1, 1, 2, 0, 0, 0);
        add(2'b10, 2'b01, 0, 10, 3, 1, 1, 2, 0, 0, 0);
        add(2'b00, 2'b00, 0, 10, 4, 2, 1, 2, 0, 0, 0);
        add(2'b11, 2'b00, 0, 10, 4, 2, 1, 2, 0, 0, 0);
        add(2'b11, 2'b11, 0, 10, 4, 2, 1, 2, 0, 0, 0);
        add(2'b00, 2'b11, 0, 10, 4, 2, 1, 2, 0, 0, 0);
        add(2'b00, 2'b00, 0, 10, 6, 2, 1, 3, 1, 1, 0);
        add(2'b00, 2'b00, 1, 2,  6, 2, 1, 0, 0, 0, 0);
        add(2'b00, 2'b01, 0, 10, 6, 2, 1, 0, 0, 0, 0);
        add(2'b01, 2'b01, 0, 10, 6, 2, 1, 0, 0, 0, 0);
        add(2'b01, 2'b00, 0, 10, 6, 2, 1, 0, 0, 0, 0);
        add(2'b00, 2'b00, 0, 10, 6, 3, 1, 0, 0, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_entry", entry_pulse, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        rst = 1'b0;
        cnt_en = 0; cnt_ex = 0; cnt_err = 0;
        mon_en = 1'b1;

        foreach (tbl[i]) begin
            clr_count = tbl[i].clr;
            drive(tbl[i].a, tbl[i].b, tbl[i].hold);
            clr_count = 1'b0;
            chk($sformatf("tbl%0d_entries", i), cnt_en, tbl[i].en);
            chk($sformatf("tbl%0d_exits", i), cnt_ex, tbl[i].ex);
            chk($sformatf("tbl%0d_errs", i), cnt_err, tbl[i].err);
            chk($sformatf("tbl%0d_occ", i), occupancy, tbl[i].occ);
            chk($sformatf("tbl%0d_full", i), full, tbl[i].full);
            chk($sformatf("tbl%0d_empty", i), empty, tbl[i].occ == 0);
            chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].ovf);
            chk($sformatf("tbl%0d_unf", i), underflow, tbl[i].unf);
        end

        // Exact pulse latency from the raw 00 edge.
        drive(2'b01, 2'b00, 10);
        drive(2'b01, 2'b01, 10);
        drive(2'b00, 2'b01, 10);
        a = 2'b00; b = 2'b00;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("lat_entry0_c%0d", k), entry_pulse[0], k == 7);
            if (k == 8) begin
                chk("lat_occ", occupancy, 1);
                chk("lat_empty", empty, 0);
            end
        end

        // Clear lands in the cycle the lane1 entry pulse is visible.
        drive(2'b10, 2'b00, 10);
        drive(2'b10, 2'b10, 10);
        drive(2'b00, 2'b10, 10);
        a = 2'b00; b = 2'b00;
        repeat (7) @(posedge clk);
        #1;
        chk("clr_pulse_seen", entry_pulse[1], 1);
        clr_count = 1'b1;
        @(posedge clk);
        #1;
        clr_count = 1'b0;
        chk("clr_occ", occupancy, 0);
        chk("clr_unf", underflow, 0);
        chk("clr_ovf", overflow, 0);
        drive(2'b00, 2'b00, 3);
        chk("clr_occ_hold", occupancy, 0);

        // Reset while lane0 sits in EN_AB.
        drive(2'b01, 2'b00, 10);
        drive(2'b01, 2'b01, 10);
        rst = 1'b1; a = 2'b00; b = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("mrst_entry", entry_pulse, 0);
        chk("mrst_err", seq_error, 0);
        chk("mrst_occ", occupancy, 0);
        chk("mrst_empty", empty, 1);
        rst = 1'b0;
        e0 = cnt_en; r0 = cnt_err; x0 = cnt_ex;
        drive(2'b00, 2'b00, 12);
        chk("mrst_no_entry", cnt_en, e0);
        chk("mrst_no_err", cnt_err, r0);
        drive(2'b00, 2'b01, 10);
        drive(2'b01, 2'b01, 10);
        drive(2'b01, 2'b00, 10);
        drive(2'b00, 2'b00, 10);
        chk("mrst_exit_after", cnt_ex, x0 + 1);
        chk("mrst_unf_after", underflow, 1);

        for (int l = 0; l < N; l++) cur[l] = 2'b00;
        for (int s = 0; s < 400; s++) begin
            for (int l = 0; l < N; l++) begin
                r = $urandom_range(0, 9);
                if (r < 8) cur[l] ^= (r[0] ? 2'b01 : 2'b10);
                else if (r == 8) cur[l] ^= 2'b11;
            end
            a = {cur[1][1], cur[0][1]};
            b = {cur[1][0], cur[0][0]};
            clr_count = ($urandom_range(0, 40) == 0);
            h = $urandom_range(1, 14);
            repeat (h) begin
                @(posedge clk);
                #1;
                clr_count = 1'b0;
            end
        end
        a = '0; b = '0;
        repeat (20) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lane_occupancy_counter.md
# lane_occupancy_counter

Multi-lane successor to the single two-sensor car-direction FSM. Each of N_LANES lanes has two beam sensors, A (outer) and B (inner). Per lane, the block synchronises and debounces both sensors and tracks the full four-phase passage, including aborts, reversals and illegal jumps. It emits one-cycle entry and exit pulses and keeps a saturating lot occupancy count with full/empty flags, feeding the display and barrier-control logic.

## Interface
- N_LANES, 2, number of sensor pairs
- CNT_W, 8, occupancy counter width
- CAPACITY, 50, lot capacity; must satisfy 1 ≤ CAPACITY < 2**CNT_W
- DEB_CYCLES, 4, consecutive stable cycles required to accept a sensor change (≥1)
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- a  in  N_LANES  raw outer sensor per lane, asynchronous
- b  in  N_LANES  raw inner sensor per lane, asynchronous
- clr_count  in  1  synchronous clear of the occupancy count and sticky flags
- entry_pulse  out  N_LANES  one-cycle pulse per completed entry
- exit_pulse  out  N_LANES  one-cycle pulse per completed exit
- seq_error  out  N_LANES  one-cycle pulse on an illegal sensor jump
- occupancy  out  CNT_W  current car count
- full  out  1  occupancy == CAPACITY
- empty  out  1  occupancy == 0
- overflow  out  1  sticky; set when an increment was clipped
- underflow  out  1  sticky; set when a decrement was clipped

## Operation
- Input conditioning, per bit:
  - 2-flop synchroniser.
  - Filter: the filtered value changes only after the synchronised value has differed from it for DEB_CYCLES consecutive cycles.
- Lane FSM runs on the filtered pair {A,B}. States:
  - IDLE
  - EN_A, EN_AB, EN_B (entry direction)
  - EX_B, EX_AB, EX_A (exit direction)
  - RESYNC
- Entry path: IDLE→EN_A on 10; EN_A→EN_AB on 11; EN_AB→EN_B on 01; EN_B→IDLE on 00, which fires entry_pulse.
- Exit path (mirror): IDLE→EX_B on 01; EX_B→EX_AB on 11; EX_AB→EX_A on 10; EX_A→IDLE on 00, which fires exit_pulse.
- Reversal steps back one phase with no pulse: EN_AB→EN_A on 10; EN_B→EN_AB on 11; EX_AB→EX_B on 01; EX_A→EX_AB on 11.
- Abort: EN_A or EX_B on 00 → IDLE, no pulse. A one-sensor touch never counts.
- Illegal transition (both filtered bits change in the same cycle, e.g. IDLE 00→11 or EN_A 10→01):
  - seq_error pulses for one cycle; the FSM enters RESYNC.
  - RESYNC→IDLE only when 00 is seen; no pulses meanwhile.
- An unchanged input holds the current state.
- Counter: net = popcount(entry_pulse) − popcount(exit_pulse), evaluated in signed arithmetic wide enough for CNT_W+1 bits plus ±N_LANES.
  - Result > CAPACITY → occupancy = CAPACITY, overflow set.
  - Result < 0 → occupancy = 0, underflow set.
  - Simultaneous pulses on different lanes are combined in a single update.
- clr_count zeroes occupancy, overflow and underflow. It has priority over a same-cycle update; pulses arriving in that cycle are discarded.
- full and empty are decoded combinationally from the occupancy register.

## Timing
- Reset values: all pulses 0; occupancy 0; full 0; empty 1; overflow 0; underflow 0.
- Reset also forces every lane FSM to IDLE and every filter output to 0, so reset mid-sequence abandons the passage without a pulse.
- Latency, raw sensor edge to filtered change: 2 + DEB_CYCLES cycles.
- Latency, filtered change to pulse: 1 cycle. Pulses are registered and last exactly 1 cycle.
- Occupancy updates on the edge after the pulse cycle, so it is visible 1 cycle after the pulse. full, empty and overflow follow in that same cycle.
- Raw glitches shorter than DEB_CYCLES cycles are fully ignored.
- A new passage may start on the cycle after returning to IDLE.

## Structure
- Package lane_pkg holds:
  - the lane state encodings as 3-bit localparams (IDLE=0 … RESYNC=7);
  - a helper function for the net-width calculation.
- Sub-module lane_fsm contains, for one lane: synchroniser, two debounce filters, FSM and pulse registers. It is instanced N_LANES times in a generate loop.
- The top level holds the popcount, the saturating counter and the flags.

## Test plan
Bench configuration: N_LANES=2, DEB_CYCLES=4, CAPACITY=3; each phase held 10 cycles.
- Lane0 raw sequence 10,11,01,00 → entry_pulse[0] high for 1 cycle, 7 cycles after the raw 00 edge; occupancy 0→1 one cycle later; empty 1→0.
- Lane0 sequences 10,00 and 10,11,10,00 → no pulses, no seq_error, occupancy unchanged. Then 01,11,10,00 from occupancy 1 → exit_pulse[0]; occupancy 0.
- A 3-cycle raw pulse on a[1] while idle → filtered value unchanged, no state change, no outputs.
- Lane1 raw 00→11 jump → seq_error[1] for 1 cycle. A following 01,00 yields no pulse (RESYNC). The next valid entry counts normally.
- At occupancy 2: same-cycle lane0 entry and lane1 exit → occupancy stays 2. Then two same-cycle entries → occupancy 3, full=1, overflow=1.
- clr_count asserted in a pulse cycle → occupancy 0, sticky flags cleared. rst asserted while lane0 is in EN_AB → no pulse, state IDLE, all outputs at reset values.
